fetch_queue: RTL

Parametrised instruction fetch unit that replaces the single-register instruction latch in front of the decoder. It streams sequential instruction words from the instruction RAM into a DEPTH-entry queue, with each entry tagged by its PC. It delivers entries to decode over a valid/ready handshake and supports branch flush with redirect. RAM read latency is a parameter; credit accounting guarantees that no returning word is ever dropped.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with zero-latency head read and synchronous clear.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers and occupancy; clear discards everything and wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry storage; left unreset since only occupied slots are ever presented.
  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: sequential RAM reads into a PC-tagged queue with flush/redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RAM_LAT  = 1,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  output logic                   ram_rd_en,
  output logic [ADDR_W-1:0]      ram_addr,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_instr,
  output logic [31:0]            out_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  fetch_pc_q;
  logic [RAM_LAT-1:0] stg_valid_q;
  logic [PC_W-1:0]  stg_pc_q [RAM_LAT];
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   credit_used;
  logic             issue;
  logic             push;
  logic             pop;
  logic             q_empty;
  logic             q_full;
  fetch_entry_t     wr_entry;
  fetch_entry_t     rd_entry;

  // Number of reads currently travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      inflight = inflight + CNT_W'(stg_valid_q[i]);
    end
  end

  // Every in-flight read already owns a queue slot, so a landing word always fits.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign issue       = (state_q == RUN) & ~flush & ~q_full &
                       (credit_used < (CNT_W + 1)'(DEPTH));
  assign ram_rd_en   = issue;
  assign ram_addr    = fetch_pc_q[ADDR_W-1:0];

  assign push      = stg_valid_q[RAM_LAT-1] & ~flush;
  assign out_valid = ~q_empty & ~flush;
  assign pop       = out_valid & out_ready;
  assign wr_entry  = '{pc: stg_pc_q[RAM_LAT-1], instr: ram_rdata};
  assign out_instr = rd_entry.instr;
  assign out_pc    = rd_entry.pc;
  assign busy      = (count != '0) | (inflight != '0);

  // Control FSM and fetch PC; flush redirects regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (flush) begin
        fetch_pc_q <= flush_pc;
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + PC_W'(1);
      end
      unique case (state_q)
        IDLE:    if (fetch_en) state_q <= RUN;
        RUN:     if (!fetch_en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // In-flight valid bits; a flush drops reads still in the RAM, including one landing now.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stg_valid_q <= '0;
    end else begin
      stg_valid_q[0] <= issue;
      for (int i = 1; i < RAM_LAT; i++) begin
        stg_valid_q[i] <= stg_valid_q[i-1];
      end
    end
  end

  // PC tags travelling alongside the valid bits.
  always_ff @(posedge clk) begin
    stg_pc_q[0] <= fetch_pc_q;
    for (int i = 1; i < RAM_LAT; i++) begin
      stg_pc_q[i] <= stg_pc_q[i-1];
    end
  end

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .push (push),
    .wdata(wr_entry),
    .pop  (pop),
    .rdata(rd_entry),
    .count(count),
    .empty(q_empty),
    .full (q_full)
  );

endmodule
